// File: rtl/imem_responder.sv
// imem_responder: read-only instruction memory with a LATENCY-cycle response to fetch.
// Latency: the response is visible LATENCY cycles after the cycle in which the request is accepted.
// Backpressure: req_ready is low while a request is counting down. stall_out tells fetch to hold its PC.
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_addr/req_ready : fetch request handshake
//   flush                        : drops the outstanding request on redirect
//   resp_valid/resp_instr/resp_pc/resp_err : response. Data holds until the next response.
//   stall_out                    : req_valid & ~req_ready
// Optional build macro IMEM_BOUNDS_CHECK_EN: addresses >= (4 << ADDR_BITS) return resp_err=1.
// When it is undefined, upper address bits wrap modulo the array size.
module imem_responder #(
  parameter int    LATENCY   = 2,
  parameter int    ADDR_BITS = 10,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_pc,
  output logic        resp_err,
  output logic        stall_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);
  localparam state_t     ACC_STATE = (LATENCY == 1) ? DONE : BUSY;

  logic [31:0] mem [DEPTH];

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] pend_addr;
  logic        accept;
  logic        load_resp;
  logic [31:0] src_addr;
  logic [31:0] rd_instr;
  logic        rd_err;

  assign req_ready  = (state != BUSY);
  assign accept     = req_valid & req_ready;
  assign stall_out  = req_valid & ~req_ready;
  assign resp_valid = (state == DONE) & ~flush;

  // A response is registered either from the pending address at the end of BUSY.
  // With LATENCY=1 it is registered straight from the request being accepted.
  assign src_addr = (state == BUSY) ? pend_addr : req_addr;

  always_comb begin
    rd_err = (src_addr[1:0] != 2'b00);
`ifdef IMEM_BOUNDS_CHECK_EN
    if ({1'b0, src_addr} >= (33'd4 << ADDR_BITS)) rd_err = 1'b1;
`endif
    rd_instr = rd_err ? 32'd0 : mem[src_addr[ADDR_BITS+1:2]];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ACC_STATE;
          cnt_nxt   = LAT_M1;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = DONE;
        end
      end
      DONE: begin
        // A flush here only kills the response being presented.
        // A request arriving alongside it is the post-redirect fetch and is still taken.
        if (accept) begin
          state_nxt = ACC_STATE;
          cnt_nxt   = LAT_M1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign load_resp = (state_nxt == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pend_addr  <= 32'd0;
      resp_instr <= 32'd0;
      resp_pc    <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) pend_addr <= req_addr;
      if (load_resp) begin
        resp_pc    <= src_addr;
        resp_instr <= rd_instr;
        resp_err   <= rd_err;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder.
// It uses three instances (LATENCY 1, 2, 3) that share stimulus; each scenario checks one instance.
// Expected responses are queued with their due cycle and compared when resp_valid fires.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        flush;
  logic [31:0] req_addr;

  logic [2:0]  rv, rr, re, st;
  logic [31:0] ri [3];
  logic [31:0] rp [3];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  exp_t        e;
  logic [31:0] model_mem [1024];

  imem_responder #(.LATENCY(1), .ADDR_BITS(10)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .req_ready(rr[0]), .resp_valid(rv[0]), .resp_instr(ri[0]), .resp_pc(rp[0]),
    .resp_err(re[0]), .stall_out(st[0]));

  imem_responder #(.LATENCY(2), .ADDR_BITS(10)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .req_ready(rr[1]), .resp_valid(rv[1]), .resp_instr(ri[1]), .resp_pc(rp[1]),
    .resp_err(re[1]), .stall_out(st[1]));

  imem_responder #(.LATENCY(3), .ADDR_BITS(10)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .req_ready(rr[2]), .resp_valid(rv[2]), .resp_instr(ri[2]), .resp_pc(rp[2]),
    .resp_err(re[2]), .stall_out(st[2]));

  function automatic exp_t mk(int at, logic [31:0] a);
    exp_t x;
    x.cyc = at;
    x.pc  = a;
    x.err = (a[1:0] != 2'b00);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a >= 32'h1000) x.err = 1'b1;
`endif
    x.instr = x.err ? 32'd0 : model_mem[a[11:2]];
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; req_addr = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({rv[k], ri[k], rp[k], re[k], rr[k], st[k]} !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_state inst%0d: got valid=%b instr=%h pc=%h err=%b ready=%b stall=%b, required 0 0 0 0 ready=1 stall=0",
                 k, rv[k], ri[k], rp[k], re[k], rr[k], st[k]);
      end
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_latency2();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 2); req_addr = 32'h0000000C; flush = 1'b0;
      if (c == 0) sb.push_back(mk(cyc + 2, 32'h0000000C));
      @(negedge clk);
      if (c == 1) begin
        tests++;
        if (st[1] !== 1'b1) begin fails++; $display("FAIL lat2_stall: got stall_out=%b, required 1", st[1]); end
      end
      if (rv[1]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL lat2_spurious: got resp_valid=1 pc=%h, required no response", rp[1]);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || ri[1] !== e.instr || rp[1] !== e.pc || re[1] !== e.err) begin
            fails++;
            $display("FAIL lat2_resp: got cyc=%0d instr=%h pc=%h err=%b, required cyc=%0d instr=%h pc=%h err=%b",
                     cyc, ri[1], rp[1], re[1], e.cyc, e.instr, e.pc, e.err);
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL lat2_missing: got %0d responses outstanding, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 3); req_addr = 32'(c * 4); flush = 1'b0;
      if (c < 3) sb.push_back(mk(cyc + 1, 32'(c * 4)));
      @(negedge clk);
      if (c < 3) begin
        tests++;
        if (st[0] !== 1'b0) begin fails++; $display("FAIL b2b_stall c%0d: got stall_out=%b, required 0", c, st[0]); end
      end
      if (rv[0]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_spurious: got resp_valid=1 pc=%h, required no response", rp[0]);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || ri[0] !== e.instr || rp[0] !== e.pc || re[0] !== e.err) begin
            fails++;
            $display("FAIL b2b_resp: got cyc=%0d instr=%h pc=%h err=%b, required cyc=%0d instr=%h pc=%h err=%b",
                     cyc, ri[0], rp[0], re[0], e.cyc, e.instr, e.pc, e.err);
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL b2b_missing: got %0d responses outstanding, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_unaligned();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0); req_addr = 32'h00000006; flush = 1'b0;
      if (c == 0) sb.push_back(mk(cyc + 2, 32'h00000006));
      @(negedge clk);
      if (rv[1]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL unaligned_spurious: got resp_valid=1 pc=%h, required no response", rp[1]);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || ri[1] !== e.instr || rp[1] !== e.pc || re[1] !== e.err) begin
            fails++;
            $display("FAIL unaligned_resp: got cyc=%0d instr=%h pc=%h err=%b, required cyc=%0d instr=%h pc=%h err=%b",
                     cyc, ri[1], rp[1], re[1], e.cyc, e.instr, e.pc, e.err);
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL unaligned_missing: got %0d responses outstanding, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_flush_busy();
    // LATENCY=3: 0x10 is flushed while counting; 0x40 is taken from IDLE the next cycle.
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0 || c == 2);
      req_addr  = (c == 0) ? 32'h00000010 : 32'h00000040;
      flush     = (c == 1);
      if (c == 2) sb.push_back(mk(cyc + 3, 32'h00000040));
      @(negedge clk);
      if (c == 1 || c == 2) begin
        tests++;
        if (rr[2] !== (c == 2)) begin fails++; $display("FAIL flush_busy_ready c%0d: got req_ready=%b, required %b", c, rr[2], (c == 2)); end
      end
      if (rv[2]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL flush_busy_spurious: got resp_valid=1 pc=%h, required no response", rp[2]);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || ri[2] !== e.instr || rp[2] !== e.pc || re[2] !== e.err) begin
            fails++;
            $display("FAIL flush_busy_resp: got cyc=%0d instr=%h pc=%h err=%b, required cyc=%0d instr=%h pc=%h err=%b",
                     cyc, ri[2], rp[2], re[2], e.cyc, e.instr, e.pc, e.err);
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL flush_busy_missing: got %0d responses outstanding, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_flush_done();
    // LATENCY=2: flush lands in DONE for 0x14 together with a new request 0x18.
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0 || c == 2);
      req_addr  = (c == 0) ? 32'h00000014 : 32'h00000018;
      flush     = (c == 2);
      if (c == 2) sb.push_back(mk(cyc + 2, 32'h00000018));
      @(negedge clk);
      if (c == 2) begin
        tests++;
        if ({rv[1], rr[1]} !== 2'b01) begin fails++; $display("FAIL flush_done_kill: got valid=%b ready=%b, required valid=0 ready=1", rv[1], rr[1]); end
      end
      if (rv[1]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL flush_done_spurious: got resp_valid=1 pc=%h, required no response", rp[1]);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || ri[1] !== e.instr || rp[1] !== e.pc || re[1] !== e.err) begin
            fails++;
            $display("FAIL flush_done_resp: got cyc=%0d instr=%h pc=%h err=%b, required cyc=%0d instr=%h pc=%h err=%b",
                     cyc, ri[1], rp[1], re[1], e.cyc, e.instr, e.pc, e.err);
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL flush_done_missing: got %0d responses outstanding, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_busy();
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0 || c == 8);
      req_addr  = (c == 0) ? 32'h00000020 : 32'h00000008;
      flush     = 1'b0;
      if (c == 2) rst = 1'b1;
      if (c == 8) sb.push_back(mk(cyc + 3, 32'h00000008));
      if (c == 1) begin
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({rv[2], ri[2], rp[2], re[2]} !== 66'd0) begin
          fails++;
          $display("FAIL reset_async: got valid=%b instr=%h pc=%h err=%b, required all 0", rv[2], ri[2], rp[2], re[2]);
        end
      end
      @(negedge clk);
      if (rv[2]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL reset_busy_spurious: got resp_valid=1 pc=%h, required no response", rp[2]);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || ri[2] !== e.instr || rp[2] !== e.pc || re[2] !== e.err) begin
            fails++;
            $display("FAIL reset_busy_resp: got cyc=%0d instr=%h pc=%h err=%b, required cyc=%0d instr=%h pc=%h err=%b",
                     cyc, ri[2], rp[2], re[2], e.cyc, e.instr, e.pc, e.err);
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL reset_busy_missing: got %0d responses outstanding, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_out_of_range();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0); req_addr = 32'h00001000; flush = 1'b0;
      if (c == 0) sb.push_back(mk(cyc + 1, 32'h00001000));
      @(negedge clk);
      if (rv[0]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL range_spurious: got resp_valid=1 pc=%h, required no response", rp[0]);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || ri[0] !== e.instr || rp[0] !== e.pc || re[0] !== e.err) begin
            fails++;
            $display("FAIL range_resp: got cyc=%0d instr=%h pc=%h err=%b, required cyc=%0d instr=%h pc=%h err=%b",
                     cyc, ri[0], rp[0], re[0], e.cyc, e.instr, e.pc, e.err);
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL range_missing: got %0d responses outstanding, required 0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = $urandom | 32'h1;
    end
    model_mem[3] = 32'h00500093;
    for (int i = 0; i < 1024; i++) begin
      u_lat1.mem[i] = model_mem[i];
      u_lat2.mem[i] = model_mem[i];
      u_lat3.mem[i] = model_mem[i];
    end
    test_reset();
    test_latency2();
    test_back_to_back();
    test_unaligned();
    test_flush_busy();
    test_flush_done();
    test_reset_busy();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
